// File: rtl/count_capture_pkg.sv
// rtl/count_capture_pkg.sv - shared sizing constants for the count capture FIFO
package count_capture_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;
    localparam int ENTRY_WIDTH   = DEFAULT_WIDTH + 1;

    function automatic int ptr_bits(input int depth);
        return $clog2(depth);
    endfunction

    localparam int PTR_WIDTH = ptr_bits(DEFAULT_DEPTH);

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with combinational head and explicit level tracking
import count_capture_pkg::*;

module sync_fifo #(
    parameter int DW    = ENTRY_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DW-1:0]            push_data,
    input  logic                     pop,
    output logic [DW-1:0]            pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = ptr_bits(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == FULL_LEVEL);
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is legal only when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);

    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/count_capture_fifo.sv
// rtl/count_capture_fifo.sv - snapshots counter values with a wrap flag into a FIFO for a reader
import count_capture_pkg::*;

module count_capture_fifo #(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         count,
    input  logic                     capture,
    input  logic                     ovf_clr,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_wrap,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level
);

    logic [WIDTH-1:0] prev_count;
    logic             wrap_pending;
    logic             wrap_event;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             push_ok;
    logic             drop;
    logic [WIDTH:0]   head;

    assign wrap_event = (prev_count == '1) && (count == '0);
    assign pop        = out_valid && out_ready;
    assign push_ok    = capture && (!fifo_full || pop);
    assign drop       = capture && !push_ok;

    assign out_valid = !fifo_empty;
    assign out_wrap  = head[WIDTH];
    assign out_data  = head[WIDTH-1:0];

    sync_fifo #(
        .DW    (WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_ok),
        .push_data ({wrap_pending | wrap_event, count}),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

    // A dropped capture keeps wrap_pending so the next stored entry still reports it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_count   <= '0;
            wrap_pending <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            prev_count <= count;
            if (push_ok) begin
                wrap_pending <= 1'b0;
            end else if (wrap_event) begin
                wrap_pending <= 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_count_capture_fifo.sv
// tb/tb_count_capture_fifo.sv - scoreboard bench for count_capture_fifo
module tb_count_capture_fifo;

    logic       clk;
    logic       rst_n;
    logic [7:0] count;
    logic       capture;
    logic       ovf_clr;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_wrap;
    logic       overflow;
    logic [2:0] level;

    int         n_checks;
    int         n_fail;
    logic [8:0] sb[$];
    logic [8:0] exp_e;

    count_capture_fifo #(.WIDTH(8), .DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .count     (count),
        .capture   (capture),
        .ovf_clr   (ovf_clr),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_wrap  (out_wrap),
        .overflow  (overflow),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic step(input logic [7:0] c, input logic cap, input logic rdy);
        count     = c;
        capture   = cap;
        out_ready = rdy;
        @(posedge clk);
        #1;
        capture = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL pop_unexpected: got wrap=%0d data=%0d, expected no entry", out_wrap, out_data);
            end else begin
                exp_e = sb.pop_front();
                if ({out_wrap, out_data} !== exp_e) begin
                    n_fail++;
                    $display("FAIL pop_entry: got wrap=%0d data=%0d, expected wrap=%0d data=%0d",
                             out_wrap, out_data, exp_e[8], exp_e[7:0]);
                end
            end
        end
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        count     = 8'd0;
        capture   = 1'b0;
        ovf_clr   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        check("reset_valid", int'(out_valid), 0);
        check("reset_level", int'(level), 0);

        // idle counting, nothing captured
        for (int i = 0; i <= 10; i++) begin
            step(8'(i), 1'b0, 1'b0);
            check("idle_valid", int'(out_valid), 0);
            check("idle_data", int'(out_data), 0);
            check("idle_ovf", int'(overflow), 0);
            check("idle_level", int'(level), 0);
        end

        // three held captures, then drain in order
        sb.push_back({1'b0, 8'd7});  step(8'd7, 1'b1, 1'b0);
        sb.push_back({1'b0, 8'd9});  step(8'd9, 1'b1, 1'b0);
        sb.push_back({1'b0, 8'd12}); step(8'd12, 1'b1, 1'b0);
        check("three_level", int'(level), 3);
        check("three_head", int'(out_data), 7);
        repeat (3) step(8'd13, 1'b0, 1'b1);
        check("three_drained_valid", int'(out_valid), 0);
        check("three_drained_sb", sb.size(), 0);

        // wrap flag: 254,255,0,1,2 then capture at 3
        step(8'd254, 1'b0, 1'b1);
        step(8'd255, 1'b0, 1'b1);
        step(8'd0, 1'b0, 1'b1);
        step(8'd1, 1'b0, 1'b1);
        step(8'd2, 1'b0, 1'b1);
        sb.push_back({1'b1, 8'd3}); step(8'd3, 1'b1, 1'b1);
        step(8'd4, 1'b0, 1'b1);
        sb.push_back({1'b0, 8'd5}); step(8'd5, 1'b1, 1'b1);
        step(8'd254, 1'b0, 1'b1);
        step(8'd255, 1'b0, 1'b1);
        sb.push_back({1'b1, 8'd0}); step(8'd0, 1'b1, 1'b1);
        step(8'd1, 1'b0, 1'b1);
        sb.push_back({1'b0, 8'd2}); step(8'd2, 1'b1, 1'b1);
        step(8'd3, 1'b0, 1'b1);
        check("wrap_drained_level", int'(level), 0);

        // fill to full, drop the fifth, push+pop at full, overflow clear
        for (int i = 0; i < 4; i++) begin
            sb.push_back({1'b0, 8'(100 + i)});
            step(8'(100 + i), 1'b1, 1'b0);
        end
        check("full_level", int'(level), 4);
        check("full_ovf_before_drop", int'(overflow), 0);
        step(8'd104, 1'b1, 1'b0);
        check("drop_ovf", int'(overflow), 1);
        check("drop_level", int'(level), 4);
        sb.push_back({1'b0, 8'd105}); step(8'd105, 1'b1, 1'b1);
        check("full_pushpop_level", int'(level), 4);
        ovf_clr = 1'b1;
        step(8'd106, 1'b1, 1'b0);
        check("ovf_set_wins", int'(overflow), 1);
        step(8'd107, 1'b0, 1'b0);
        ovf_clr = 1'b0;
        check("ovf_cleared", int'(overflow), 0);
        step(8'd255, 1'b0, 1'b0);
        step(8'd0, 1'b1, 1'b0);
        check("wrap_drop_ovf", int'(overflow), 1);
        step(8'd1, 1'b0, 1'b0);
        repeat (4) step(8'd2, 1'b0, 1'b1);
        check("full_drained_level", int'(level), 0);
        sb.push_back({1'b1, 8'd3}); step(8'd3, 1'b1, 1'b1);
        step(8'd4, 1'b0, 1'b1);

        // asynchronous reset with entries held
        step(8'd50, 1'b1, 1'b0);
        step(8'd51, 1'b1, 1'b0);
        check("prereset_level", int'(level), 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", int'(out_valid), 0);
        check("async_rst_data", int'(out_data), 0);
        check("async_rst_level", int'(level), 0);
        check("async_rst_ovf", int'(overflow), 0);
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back({1'b0, 8'd20}); step(8'd20, 1'b1, 1'b0);
        check("post_rst_valid", int'(out_valid), 1);
        check("post_rst_data", int'(out_data), 20);
        step(8'd21, 1'b0, 1'b1);

        // streaming capture with continuous reads
        for (int i = 0; i < 8; i++) begin
            sb.push_back({1'b0, 8'(40 + i)});
            step(8'(40 + i), 1'b1, 1'b1);
            check("stream_level", int'(level), 1);
        end
        step(8'd48, 1'b0, 1'b1);
        step(8'd49, 1'b0, 1'b0);
        check("final_valid", int'(out_valid), 0);
        check("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/count_capture_fifo.md
Name: count_capture_fifo

Overview:
- Downstream consumer of the 8-bit synchronous counter's count output.
- On each capture strobe, snapshots the current count together with a "wrapped since last capture" flag into a small FIFO.
- Presents snapshots to a reader over a valid/ready handshake, so count samples survive until software or a logger drains them.
- Runs in the counter's clock domain; no CDC.

Parameters:
- WIDTH, 8: counter/count width in bits.
- DEPTH, 4: FIFO entries; power of 2, at least 2.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- count  input  WIDTH  counter value, sampled every rising edge.
- capture  input  1  single-cycle strobe requesting a snapshot.
- ovf_clr  input  1  clears the sticky overflow flag.
- out_ready  input  1  reader accepts the head entry.
- out_valid  output  1  head entry valid.
- out_data  output  WIDTH  captured count at head; 0 when empty.
- out_wrap  output  1  head entry flag: a wrap occurred since the previous accepted capture.
- overflow  output  1  sticky: a capture was dropped because the FIFO was full.
- level  output  $clog2(DEPTH)+1  current number of entries.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_wrap=0, overflow=0, level=0.
  - Read/write pointers, prev_count and wrap_pending all go to 0.
  - Asserting reset mid-operation discards all entries immediately.
- prev_count: registers count every cycle.
- Wrap event: in any cycle where prev_count == all-ones and count == 0. Loads or other jumps are not wraps.
- wrap_pending:
  - Set on a wrap event.
  - Cleared when a capture is accepted.
  - A wrap and an accepted capture in the same cycle store wrap=1 in that entry; pending ends at 0.
- Push: capture=1 and (level<DEPTH, or pop in the same cycle).
  - Stores {wrap_pending OR wrap_event, count} at the write pointer.
  - The value stored is the count present on that clock edge.
- Pop: out_valid && out_ready. Advances the read pointer.
- Simultaneous push and pop: level unchanged. Allowed at full and at empty.
  - At empty with no bypass, the pushed entry appears next cycle. The pop is impossible since out_valid=0.
- Full and capture without pop:
  - Capture is dropped and overflow set to 1.
  - wrap_pending is retained, so the wrap is reported on the next accepted capture.
- ovf_clr:
  - Clears overflow next edge.
  - If a drop happens in the same cycle, set wins (overflow stays 1).
- Latency: capture at edge N gives out_valid=1 after edge N, with out_data = count seen at edge N.
- Output timing:
  - out_data and out_wrap reflect the head entry combinationally from storage, gated to 0 when empty.
  - out_valid = (level != 0).
- out_valid and out_data remain stable while out_valid=1 and out_ready=0.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. level is tracked separately to distinguish full from empty.
- Counter wrap and pointer wrap are independent.

Decomposition:
- Package count_capture_pkg holds:
  - Default WIDTH and DEPTH.
  - Entry width WIDTH+1 (entry = {wrap, count}).
  - Pointer-width constant derived via $clog2.
- One natural sub-module: sync_fifo.
  - Generic width and depth, with push/pop/full/empty/level.
  - Instantiated with data width WIDTH+1.
- The top holds the wrap detector, wrap_pending, overflow and capture gating.

Test Plan:
- Reset then idle, count stepping 0..10 with no capture -> out_valid=0, out_data=0, overflow=0, level=0 throughout.
- Captures with count=7, then 9, then 12, out_ready=0 -> level=3; raise out_ready -> entries read in order 7,9,12, all with out_wrap=0, then out_valid=0.
- Count runs 254,255,0,1 with capture at count=3 -> entry data=3, out_wrap=1; next capture at 5 -> out_wrap=0. Capture at the exact 255->0 edge -> data=0, wrap=1.
- DEPTH=4: five captures with no pop -> level=4 and overflow=1, with the fifth value dropped. Capture plus pop at full -> level stays 4 and new value accepted. ovf_clr -> overflow=0.
- Hold out_ready=0 with 2 entries, then drop rst_n mid-cycle -> outputs 0 immediately, before the next clock edge. After release, first capture at count=20 -> out_data=20 after one edge.
- Capture with out_ready=1 every cycle while count increments from 40 -> steady level=1, with each read value one greater than the previous one.
